// File: rtl/proc_mem_pkg.sv
// Shared processor-memory definitions: DM geometry, SRAM strobe levels and the
// DM dump reader state encoding.
package proc_mem_pkg;

  localparam int unsigned DM_ADDR_WIDTH = 11;
  localparam int unsigned DM_DATA_WIDTH = 32;
  localparam int unsigned DM_DEPTH      = 2048;

  // SRAM strobes are active-low
  localparam logic MEM_EN  = 1'b0;
  localparam logic MEM_DIS = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } dump_state_e;

endpackage

// File: rtl/dump_skid_fifo.sv
// Two-entry FIFO holding captured DM words ({last, addr, data}) until the
// consumer takes them on the valid/ready interface.
module dump_skid_fifo #(
  parameter int unsigned Width = 44
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             pop;

  assign valid_o = (count_q != 2'd0);
  assign pop     = valid_o & ready_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dm_dump_reader.sv
// Reads a programmable DM window through the SRAM port and streams each word,
// tagged with its address and a last flag, on a valid/ready interface.
module dm_dump_reader
  import proc_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DM_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  word_count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  dm_cen_o,
  output logic                  dm_wen_o,
  output logic                  dm_oen_o,
  output logic [ADDR_WIDTH-1:0] dm_addr_o,
  input  logic [DATA_WIDTH-1:0] dm_dataout_i,
  output logic                  dump_valid_o,
  input  logic                  dump_ready_i,
  output logic [ADDR_WIDTH-1:0] dump_addr_o,
  output logic [DATA_WIDTH-1:0] dump_data_o,
  output logic                  dump_last_o
);

  localparam int unsigned FifoWidth = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] MaxCount = CNT_WIDTH'(2 ** ADDR_WIDTH);

  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;

  // Read issued last cycle: its data is on dm_dataout_i during this cycle
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic [ADDR_WIDTH-1:0] inflight_addr_q;

  logic                  issue;
  logic                  issue_last;
  logic                  pop;
  logic [1:0]            fifo_count;
  logic [2:0]            occupancy;
  logic [CNT_WIDTH-1:0]  clamped_count;
  logic [FifoWidth-1:0]  fifo_rdata;

  assign clamped_count = (word_count_i > MaxCount) ? MaxCount : word_count_i;
  assign pop           = dump_valid_o & dump_ready_i;

  // Words buffered or in flight after this cycle's pop; keeping it below two
  // leaves room for the word issued now.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == StRead) && (occupancy < 3'd2);
  assign issue_last = (issued_q == count_q - 1'b1);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    issued_d = issued_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d   = base_addr_i;
          count_d  = clamped_count;
          issued_d = '0;
          state_d  = (clamped_count == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        if (issue) begin
          addr_d   = addr_q + 1'b1;
          issued_d = issued_q + 1'b1;
          if (issue_last) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Finish as the final word leaves so done lands right after its transfer
        if (!inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      count_q         <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      count_q         <= count_d;
      issued_q        <= issued_d;
      inflight_q      <= issue;
      inflight_last_q <= issue & issue_last;
      inflight_addr_q <= addr_q;
    end
  end

  dump_skid_fifo #(
    .Width(FifoWidth)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_data_i({inflight_last_q, inflight_addr_q, dm_dataout_i}),
    .valid_o    (dump_valid_o),
    .ready_i    (dump_ready_i),
    .data_o     (fifo_rdata),
    .count_o    (fifo_count)
  );

  assign {dump_last_o, dump_addr_o, dump_data_o} = fifo_rdata;

  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StDone);
  assign dm_cen_o  = issue ? MEM_EN : MEM_DIS;
  assign dm_wen_o  = MEM_DIS;
  assign dm_oen_o  = busy_o ? MEM_EN : MEM_DIS;
  assign dm_addr_o = addr_q;

endmodule
